// File: rtl/ack_arbiter_n_if.sv
// Acknowledge-bus bundle between the requesting engines (master) and ack_arbiter_n (slave).
// Carries the level requests, completion strobes and the registered grant/status outputs.
interface ack_arbiter_n_if #(
    parameter int N_SRC = 4,
    parameter int ID_W  = $clog2(N_SRC)
);
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] done;
    logic [N_SRC-1:0] grant;
    logic             grant_valid;
    logic [ID_W-1:0]  winner_id;
    logic             ack_event;
    logic             busy;
    logic             timeout_err;
    logic [ID_W-1:0]  timeout_id;

    modport master (
        output req, done,
        input  grant, grant_valid, winner_id, ack_event, busy, timeout_err, timeout_id
    );

    modport slave (
        input  req, done,
        output grant, grant_valid, winner_id, ack_event, busy, timeout_err, timeout_id
    );
endinterface

// File: rtl/ack_arbiter_n.sv
// N-source ACK-bus arbiter (fixed or round-robin): grant registers 1 clk after req, one GAP cycle after release.
// No pre-emption; the grant is held until done, abort (req drop) or timeout of the winner.
module ack_arbiter_n #(
    parameter int N_SRC   = 4,
    parameter int ID_W    = $clog2(N_SRC),
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    ack_arbiter_n_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]       state;
    logic [N_SRC-1:0] grant_q;
    logic             grant_valid_q;
    logic [ID_W-1:0]  winner_q;
    logic             timeout_err_q;
    logic [ID_W-1:0]  timeout_id_q;
    logic [ID_W-1:0]  last_winner;
    logic [CW-1:0]    cnt;

    logic             sel_vld;
    logic [ID_W-1:0]  sel_id;
    logic             win_done;
    logic             win_req;
    logic             to_hit;

    // Search order starts after the previous winner in round-robin, at 0 otherwise.
    always_comb begin : sel_blk
        int              s;
        logic [ID_W-1:0] idx;
        s       = 0;
        idx     = '0;
        sel_vld = 1'b0;
        sel_id  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (RR_MODE != 0) s = (int'(last_winner) + 1 + i) % N_SRC;
            else              s = i;
            idx = ID_W'(s);
            if (!sel_vld && bus.req[idx]) begin
                sel_vld = 1'b1;
                sel_id  = idx;
            end
        end
    end

    assign win_done = bus.done[winner_q];
    assign win_req  = bus.req[winner_q];
    assign to_hit   = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            winner_q      <= '1;
            timeout_err_q <= 1'b0;
            timeout_id_q  <= '1;
            last_winner   <= ID_W'(N_SRC - 1);
            cnt           <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        state         <= S_GRANT;
                        grant_q       <= N_SRC'(1) << sel_id;
                        grant_valid_q <= 1'b1;
                        winner_q      <= sel_id;
                        last_winner   <= sel_id;
                        cnt           <= '0;
                    end
                end
                S_GRANT: begin
                    if (win_done || !win_req || to_hit) begin
                        state         <= S_GAP;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        winner_q      <= '1;
                        // done and abort both take precedence over a coincident timeout.
                        if (!win_done && win_req) begin
                            timeout_err_q <= 1'b1;
                            timeout_id_q  <= winner_q;
                        end
                    end else if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.winner_id   = winner_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.timeout_id  = timeout_id_q;
    assign bus.busy        = (state == S_GRANT) || (state == S_GAP);
    assign bus.ack_event   = |bus.req;
endmodule

// File: tb/tb_ack_arbiter_n.sv
// Scoreboard bench: dut0 fixed priority, dut1 round-robin, both TIMEOUT=8.
// Stimulus pushes expected grant/timeout events (cycle, id); negedge monitors pop and compare.
module tb_ack_arbiter_n;
    typedef struct {
        int cyc;
        int id;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t gq0[$];
    exp_t gq1[$];
    exp_t tq0[$];
    exp_t tq1[$];
    exp_t e0;
    exp_t e1;
    logic gv0_prev = 1'b0;
    logic gv1_prev = 1'b0;

    ack_arbiter_n_if #(.N_SRC(4)) a ();
    ack_arbiter_n_if #(.N_SRC(4)) b ();

    ack_arbiter_n #(.N_SRC(4), .RR_MODE(0), .TIMEOUT(8)) dut0 (.clk(clk), .rst(rst), .bus(a.slave));
    ack_arbiter_n #(.N_SRC(4), .RR_MODE(1), .TIMEOUT(8)) dut1 (.clk(clk), .rst(rst), .bus(b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input int c, input int id);
        exp_t e;
        e.cyc = c;
        e.id  = id;
        return e;
    endfunction

    always @(negedge clk) begin
        chk("inv0", int'((a.grant_valid == (|a.grant)) && (a.grant_valid || a.winner_id == 2'b11)), 1);
        if (a.grant_valid && !gv0_prev) begin
            if (gq0.size() == 0) begin
                total++; bad++;
                $display("FAIL gnt0_unexpected actual id=%0d at cyc=%0d required none", a.winner_id, cyc);
            end else begin
                e0 = gq0.pop_front();
                chk("gnt0_cyc", cyc, e0.cyc);
                chk("gnt0_id", int'(a.winner_id), e0.id);
                chk("gnt0_onehot", int'(a.grant), 1 << e0.id);
            end
        end
        if (a.timeout_err) begin
            if (tq0.size() == 0) begin
                total++; bad++;
                $display("FAIL tmo0_unexpected actual=1 at cyc=%0d required=0", cyc);
            end else begin
                e0 = tq0.pop_front();
                chk("tmo0_cyc", cyc, e0.cyc);
                chk("tmo0_id", int'(a.timeout_id), e0.id);
            end
        end
        gv0_prev = a.grant_valid;
    end

    always @(negedge clk) begin
        chk("inv1", int'((b.grant_valid == (|b.grant)) && (b.grant_valid || b.winner_id == 2'b11)), 1);
        if (b.grant_valid && !gv1_prev) begin
            if (gq1.size() == 0) begin
                total++; bad++;
                $display("FAIL gnt1_unexpected actual id=%0d at cyc=%0d required none", b.winner_id, cyc);
            end else begin
                e1 = gq1.pop_front();
                chk("gnt1_cyc", cyc, e1.cyc);
                chk("gnt1_id", int'(b.winner_id), e1.id);
                chk("gnt1_onehot", int'(b.grant), 1 << e1.id);
            end
        end
        if (b.timeout_err) begin
            if (tq1.size() == 0) begin
                total++; bad++;
                $display("FAIL tmo1_unexpected actual=1 at cyc=%0d required=0", cyc);
            end else begin
                e1 = tq1.pop_front();
                chk("tmo1_cyc", cyc, e1.cyc);
                chk("tmo1_id", int'(b.timeout_id), e1.id);
            end
        end
        gv1_prev = b.grant_valid;
    end

    initial begin
        int c, d, g, h, r, s, t;
        rst    = 1'b1;
        a.req  = '0;
        a.done = '0;
        b.req  = '0;
        b.done = '0;
        tick(2);
        @(negedge clk);
        chk("rst_grant", int'(a.grant), 0);
        chk("rst_gv", int'(a.grant_valid), 0);
        chk("rst_wid", int'(a.winner_id), 3);
        chk("rst_busy", int'(a.busy), 0);
        chk("rst_terr", int'(a.timeout_err), 0);
        chk("rst_tid", int'(a.timeout_id), 3);
        chk("rst_wid1", int'(b.winner_id), 3);
        tick(1);
        rst = 1'b0;
        tick(1);

        // Fixed priority: lowest of 1,2,3 wins; next grant 3 cycles after done.
        c = cyc;
        a.req = 4'b1110;
        gq0.push_back(mk(c + 1, 1));
        @(negedge clk);
        chk("ack_event", int'(a.ack_event), 1);
        tick(3);
        d = cyc;
        a.done = 4'b0010;
        gq0.push_back(mk(d + 3, 2));
        tick(1);
        a.done = '0;
        a.req  = 4'b1100;
        @(negedge clk);
        chk("gap_busy", int'(a.busy), 1);
        chk("gap_gv", int'(a.grant_valid), 0);
        tick(2);
        d = cyc;
        a.done = 4'b0100;
        gq0.push_back(mk(d + 3, 3));
        tick(1);
        a.done = '0;
        a.req  = 4'b1000;
        tick(3);
        a.done = 4'b0001;
        tick(1);
        a.done = '0;
        @(negedge clk);
        chk("spurious_done_hold", int'(a.grant), 8);
        tick(1);
        a.req = '0;
        tick(1);
        @(negedge clk);
        chk("abort_gv", int'(a.grant_valid), 0);
        chk("abort_terr", int'(a.timeout_err), 0);
        tick(3);

        // Timeout: 8-cycle grant, error pulse in GAP, then re-grant.
        g = cyc;
        a.req = 4'b0100;
        gq0.push_back(mk(g + 1, 2));
        tq0.push_back(mk(g + 9, 2));
        gq0.push_back(mk(g + 11, 2));
        tick(12);
        a.req = '0;
        tick(4);
        @(negedge clk);
        chk("tid_sticky", int'(a.timeout_id), 2);
        tick(1);

        // done coincident with timeout: no error.
        h = cyc;
        a.req = 4'b0010;
        gq0.push_back(mk(h + 1, 1));
        tick(8);
        a.done = 4'b0010;
        tick(1);
        a.done = '0;
        a.req  = '0;
        @(negedge clk);
        chk("both_gv", int'(a.grant_valid), 0);
        chk("both_terr", int'(a.timeout_err), 0);
        tick(3);

        // Round-robin rotation with all four requesting.
        r = cyc;
        b.req = 4'b1111;
        for (int k = 0; k < 5; k++) gq1.push_back(mk(r + 1 + 4 * k, k % 4));
        tick(1);
        for (int k = 0; k < 5; k++) begin
            tick(1);
            b.done = 4'b0001 << (k % 4);
            tick(1);
            b.done = '0;
            if (k == 4) b.req = '0;
            tick(2);
        end
        tick(2);

        // Asynchronous reset in the middle of a grant.
        s = cyc;
        b.req = 4'b0100;
        gq1.push_back(mk(s + 1, 2));
        tick(2);
        rst   = 1'b1;
        b.req = '0;
        #1;
        chk("arst_grant", int'(b.grant), 0);
        chk("arst_gv", int'(b.grant_valid), 0);
        chk("arst_wid", int'(b.winner_id), 3);
        chk("arst_busy", int'(b.busy), 0);
        chk("arst_terr", int'(b.timeout_err), 0);
        chk("arst_tid0", int'(a.timeout_id), 3);
        tick(2);
        rst   = 1'b0;
        b.req = 4'b1000;
        t = cyc;
        gq1.push_back(mk(t + 1, 3));
        tick(2);
        b.req = '0;
        tick(4);

        chk("gq0_left", gq0.size(), 0);
        chk("gq1_left", gq1.size(), 0);
        chk("tq0_left", tq0.size(), 0);
        chk("tq1_left", tq1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ack_arbiter_n.md
# ack_arbiter_n

Parametrised, registered successor to the 4-source ACK arbiter on the crypto interconnect's acknowledge bus. It arbitrates among N_SRC requesters (MEM, SHA, AES, CTRL and future engines) using either fixed lowest-ID priority or round-robin. It holds a one-hot grant until the winner signals completion, aborts, or times out, then inserts one bus-turnaround cycle before re-arbitrating. It sits between the modules' latched request sideband and their ack_ready inputs, and it broadcasts the winner ID to all modules.

## Interface
Parameters:
- N_SRC, 4: number of requesters, 2..16; ID i = requester i (0 = MEM, 1 = SHA, 2 = AES, 3 = CTRL at default).
- ID_W, $clog2(N_SRC): width of winner_id.
- RR_MODE, 0: 0 = fixed priority (lowest ID wins); 1 = round-robin.
- TIMEOUT, 64: maximum grant hold in cycles, 2..65535; 0 disables the timeout.

Ports:
- clk  input  1  block clock.
- rst  input  1  reset; asynchronous, active-high.
- req  input  N_SRC  level request per source; held until done or abort.
- done  input  N_SRC  per-source single-cycle completion strobe; only done[winner_id] is honoured.
- grant  output  N_SRC  one-hot registered ready to the winner.
- grant_valid  output  1  high while any grant bit is set.
- winner_id  output  ID_W  ID of the current winner; all ones when none.
- ack_event  output  1  combinational OR of req.
- busy  output  1  high in GRANT and GAP.
- timeout_err  output  1  one-cycle pulse on forced release.
- timeout_id  output  ID_W  ID of the last timed-out source; sticky until the next timeout.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: one source owns the bus.
  - GAP: one-cycle turnaround, no grant.
- IDLE:
  - If req is nonzero, pick a winner and go to GRANT; the grant bit, grant_valid and winner_id all register on the same edge.
  - If req is zero, stay in IDLE.
- Winner selection:
  - RR_MODE=0: lowest set index of req.
  - RR_MODE=1: first set index at or after (last_winner+1) mod N_SRC, searching upward with wrap.
  - last_winner updates on every grant; its reset value is N_SRC-1, so the first search starts at 0.
- GRANT exits to GAP on the first of these, with priority in the order listed:
  - done[winner]: normal release.
  - req[winner] low: abort; no error.
  - hold counter == TIMEOUT-1 while TIMEOUT != 0: forced release; timeout_err pulses and timeout_id ← winner_id.
- Release behaviour:
  - done[winner] and the timeout hit in the same cycle: treated as done; no error.
  - done from non-winners is ignored.
  - A change in req from other sources during GRANT is ignored; there is no pre-emption.
- GAP always goes to IDLE after 1 cycle. Requests present in GAP are arbitrated in the following IDLE cycle.
- Hold counter:
  - Width: $clog2(TIMEOUT+1).
  - Cleared on entry to GRANT; increments each GRANT cycle; saturates.
- A source whose req is still high after release re-competes normally. In RR_MODE=1 it loses to any other pending source.

## Timing
- Reset values:
  - grant=0, grant_valid=0, busy=0, timeout_err=0.
  - winner_id all ones; timeout_id all ones.
  - state IDLE; last_winner N_SRC-1; counter 0.
  - Reset asserted mid-GRANT drops grant asynchronously; no timeout_err is raised.
- Request-to-grant latency: 1 clk (req high at edge k → grant at edge k+1).
- Release-to-next-grant: done at edge k → grant drops at k+1 (GAP) → IDLE at k+2 → new grant at k+3. Minimum grant-to-grant spacing is 3 cycles after done.
- Timeout: grant is high for exactly TIMEOUT cycles. timeout_err is high in the first GAP cycle.
- All outputs except ack_event are registered; there are no combinational paths from req/done to grant.

## Test plan
- Fixed priority, N_SRC=4, RR_MODE=0: req=4'b1110 at once → grant=4'b0010, winner_id=1 after 1 clk. done[1] → GAP → grant=4'b0100 three cycles after done.
- Round-robin, RR_MODE=1: req=4'b1111 held, each winner pulses done after 2 cycles → winner_id sequence 0,1,2,3,0; no source is granted twice in a row.
- Timeout, TIMEOUT=8: req[2] held with no done → grant[2] high for exactly 8 cycles. timeout_err pulses once with timeout_id=2, then grant[2] is re-issued after GAP.
- Abort and spurious done: winner 3 drops req at cycle 2 → release with timeout_err=0. done[0] while 3 owns the bus → no effect.
- Simultaneous done and timeout at count 7 with TIMEOUT=8 → release with timeout_err=0.
- Reset mid-grant: rst asserted with grant=4'b0100 → all outputs take their reset values immediately (winner_id=2'b11). After reset, req=4'b1000 in RR_MODE=1 → winner 3 granted 1 clk later.
